// File: rtl/wb_port_arb.sv
// wb_port_arb: two-requester round-robin arbiter in front of a single Wishbone interface port
module wb_port_arb #(
  parameter int DATA_WL = 16,
  parameter int ADR_WL  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               a_reset_l,
  input  logic               m0_req_in,
  input  logic               m0_we_in,
  input  logic [ADR_WL-1:0]  m0_adr_in,
  input  logic [DATA_WL-1:0] m0_data_in,
  output logic               m0_gnt_out,
  output logic               m0_valid_out,
  output logic               m0_err_out,
  input  logic               m1_req_in,
  input  logic               m1_we_in,
  input  logic [ADR_WL-1:0]  m1_adr_in,
  input  logic [DATA_WL-1:0] m1_data_in,
  output logic               m1_gnt_out,
  output logic               m1_valid_out,
  output logic               m1_err_out,
  output logic [DATA_WL-1:0] rd_data_out,
  output logic               start_out,
  output logic               we_out,
  output logic [ADR_WL-1:0]  adr_out,
  output logic [DATA_WL-1:0] data_out,
  input  logic               busy_in,
  input  logic               valid_in,
  input  logic [DATA_WL-1:0] data_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Abort fires on the last WAIT cycle so the err pulse lands TIMEOUT+1 cycles after start
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] timer;
  logic       win, last_gnt, sel, grant, done_ok, done_to;

  assign start_out = (state == ISSUE);

  // Next-state logic: arbitration in IDLE, completion or timeout in WAIT
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    sel      = (m0_req_in && m1_req_in) ? ~last_gnt : m1_req_in;
    case (state)
      IDLE: begin
        if ((m0_req_in || m1_req_in) && !busy_in) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (valid_in) begin
          done_ok  = 1'b1;
          state_nx = IDLE;
        end else if (timer == TMO_LAST) begin
          done_to  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) state <= IDLE;
    else state <= state_nx;
  end

  // Wait timer: cleared on issue, counts WAIT cycles without completion
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) timer <= '0;
    else if (state == ISSUE) timer <= '0;
    else if (state == WAIT && !valid_in) timer <= timer + 8'd1;
  end

  // Grant, request capture, completion pulses and read data
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      win          <= 1'b0;
      last_gnt     <= 1'b1;
      m0_gnt_out   <= 1'b0;
      m1_gnt_out   <= 1'b0;
      m0_valid_out <= 1'b0;
      m1_valid_out <= 1'b0;
      m0_err_out   <= 1'b0;
      m1_err_out   <= 1'b0;
      we_out       <= 1'b0;
      adr_out      <= '0;
      data_out     <= '0;
      rd_data_out  <= '0;
    end else begin
      m0_valid_out <= done_ok & ~win;
      m1_valid_out <= done_ok & win;
      m0_err_out   <= done_to & ~win;
      m1_err_out   <= done_to & win;
      if (grant) begin
        win        <= sel;
        m0_gnt_out <= ~sel;
        m1_gnt_out <= sel;
        we_out     <= sel ? m1_we_in : m0_we_in;
        adr_out    <= sel ? m1_adr_in : m0_adr_in;
        data_out   <= sel ? m1_data_in : m0_data_in;
      end
      if (done_ok || done_to) begin
        m0_gnt_out <= 1'b0;
        m1_gnt_out <= 1'b0;
        last_gnt   <= win;
      end
      if (done_ok) rd_data_out <= data_in;
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: directed stimulus with a transaction-level reference model for wb_port_arb
module tb_wb_port_arb;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_gnt_out, m0_valid_out, m0_err_out;
  logic        m1_gnt_out, m1_valid_out, m1_err_out;
  logic [15:0] rd_data_out, adr_out, data_out, data_in;
  logic        start_out, we_out, busy_in, valid_in;

  int checks = 0, failures = 0, b2b = 0;
  logic prev_st = 1'b0;

  always #5 clk = ~clk;

  wb_port_arb #(.DATA_WL(16), .ADR_WL(16), .TIMEOUT(TO)) dut (
    .clk(clk), .a_reset_l(rst_n),
    .m0_req_in(m0_req), .m0_we_in(m0_we), .m0_adr_in(m0_adr), .m0_data_in(m0_dat),
    .m0_gnt_out(m0_gnt_out), .m0_valid_out(m0_valid_out), .m0_err_out(m0_err_out),
    .m1_req_in(m1_req), .m1_we_in(m1_we), .m1_adr_in(m1_adr), .m1_data_in(m1_dat),
    .m1_gnt_out(m1_gnt_out), .m1_valid_out(m1_valid_out), .m1_err_out(m1_err_out),
    .rd_data_out(rd_data_out), .start_out(start_out), .we_out(we_out),
    .adr_out(adr_out), .data_out(data_out),
    .busy_in(busy_in), .valid_in(valid_in), .data_in(data_in)
  );

  // Reference model: one transaction at a time, age = WAIT cycles elapsed since start
  logic        m_act = 1'b0, m_own = 1'b0, m_last = 1'b1;
  int          m_age = 0;
  logic        e_g0 = 0, e_g1 = 0, e_st = 0, e_we = 0, e_v0 = 0, e_v1 = 0, e_e0 = 0, e_e1 = 0;
  logic [15:0] e_adr = 0, e_dat = 0, e_rd = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_last = 1; m_own = 0; m_age = 0;
      e_g0 = 0; e_g1 = 0; e_st = 0; e_we = 0; e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0;
      e_adr = 0; e_dat = 0; e_rd = 0;
    end else begin
      e_st = 0; e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0;
      if (!m_act) begin
        if ((m0_req || m1_req) && !busy_in) begin
          m_own = (m0_req && m1_req) ? !m_last : m1_req;
          e_we  = m_own ? m1_we : m0_we;
          e_adr = m_own ? m1_adr : m0_adr;
          e_dat = m_own ? m1_dat : m0_dat;
          e_g0 = !m_own; e_g1 = m_own; e_st = 1;
          m_act = 1; m_age = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (valid_in || m_age == TO) begin
        if (valid_in) begin
          e_rd = data_in; e_v0 = !m_own; e_v1 = m_own;
        end else begin
          e_e0 = !m_own; e_e1 = m_own;
        end
        e_g0 = 0; e_g1 = 0; m_last = m_own; m_act = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ctl", {m0_gnt_out, m1_gnt_out, start_out, we_out, m0_valid_out, m1_valid_out, m0_err_out, m1_err_out},
        {e_g0, e_g1, e_st, e_we, e_v0, e_v1, e_e0, e_e1});
    chk("adr", adr_out, e_adr);
    chk("wdata", data_out, e_dat);
    chk("rdata", rd_data_out, e_rd);
    if (prev_st && start_out) b2b++;
    prev_st = start_out;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!start_out && n < 30);
    chk(nm, start_out, 1);
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); tick(); rst_n = 1;
  endtask

  initial begin
    int n;
    logic seen_v;
    rst_n = 0; m0_req = 0; m0_we = 0; m0_adr = 0; m0_dat = 0;
    m1_req = 0; m1_we = 0; m1_adr = 0; m1_dat = 0;
    busy_in = 0; valid_in = 0; data_in = 0;
    tick(); tick();
    chk("reset_outs", {m0_gnt_out, m1_gnt_out, start_out, we_out, m0_valid_out, m1_valid_out,
                       m0_err_out, m1_err_out, adr_out, data_out, rd_data_out}, 0);
    rst_n = 1;
    tick();
    // m0 read at 0x0010, completion three cycles after start
    m0_req = 1; m0_we = 0; m0_adr = 16'h0010;
    wait_start("t1_start");
    chk("t1_gnt", {m0_gnt_out, m1_gnt_out}, 2'b10);
    m0_req = 0; m0_adr = 16'hFFFF;
    tick(); tick(); tick();
    valid_in = 1; data_in = 16'hBEEF;
    tick();
    valid_in = 0;
    chk("t1_valid", {m0_valid_out, m1_valid_out, m1_gnt_out, m1_err_out}, 4'b1000);
    chk("t1_rd", rd_data_out, 16'hBEEF);
    chk("t1_adr", adr_out, 16'h0010);
    // both requesters held across four transactions
    do_reset();
    tick();
    m0_req = 1; m1_req = 1; m0_adr = 16'h0100; m1_adr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      wait_start("t2_start");
      chk("t2_rr", {m0_gnt_out, m1_gnt_out}, (i % 2) ? 2'b01 : 2'b10);
      tick(); tick();
      valid_in = 1; data_in = 16'hA000 + 16'(i);
      tick();
      valid_in = 0;
      if (i == 3) begin m0_req = 0; m1_req = 0; end
    end
    tick();
    chk("t2_b2b_start", b2b, 0);
    // m1 write that never completes
    m1_req = 1; m1_we = 1; m1_adr = 16'h0400; m1_dat = 16'h1234;
    wait_start("t3_start");
    chk("t3_bus", {we_out, adr_out, data_out}, {1'b1, 16'h0400, 16'h1234});
    m1_req = 0; m1_adr = 16'hDEAD; m1_we = 0;
    n = 0; seen_v = 0;
    do begin tick(); n++; seen_v |= m1_valid_out; end while (!m1_err_out && n < 20);
    chk("t3_err_lat", n, TO + 1);
    chk("t3_no_valid", seen_v, 0);
    chk("t3_rd_kept", rd_data_out, 16'hA003);
    // busy holds off the grant
    busy_in = 1; m0_req = 1; m0_we = 1; m0_adr = 16'h0020; m0_dat = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_busy_hold", {m0_gnt_out, m1_gnt_out, start_out}, 0);
    end
    busy_in = 0;
    tick();
    chk("t4_start", {start_out, m0_gnt_out}, 2'b11);
    valid_in = 1; data_in = 16'h9999; m0_req = 0;
    tick();
    chk("t4_issue_valid_ignored", m0_valid_out, 0);
    tick();
    valid_in = 0;
    chk("t4_valid", m0_valid_out, 1);
    // reset during WAIT
    m0_req = 1; m0_we = 0; m0_adr = 16'h0030;
    wait_start("t5_start");
    m0_req = 0;
    tick();
    rst_n = 0;
    #1;
    chk("t5_async_reset", {m0_gnt_out, m1_gnt_out, start_out, we_out, m0_valid_out, m1_valid_out,
                           m0_err_out, m1_err_out, adr_out, data_out, rd_data_out}, 0);
    tick();
    rst_n = 1; valid_in = 1; data_in = 16'h1111;
    tick();
    valid_in = 0;
    chk("t5_no_pulse", {m0_gnt_out, m0_valid_out, m0_err_out, rd_data_out}, 0);
    tick();
    m0_req = 1;
    wait_start("t5_restart");
    m0_req = 0;
    tick();
    valid_in = 1; data_in = 16'h7777;
    tick();
    valid_in = 0;
    chk("t5_valid", {m0_valid_out, rd_data_out}, {1'b1, 16'h7777});
    // completion on the timeout cycle
    m0_req = 1;
    wait_start("t6_start");
    m0_req = 0;
    repeat (TO) tick();
    valid_in = 1; data_in = 16'h4242;
    tick();
    valid_in = 0;
    chk("t6_valid_wins", {m0_valid_out, m0_err_out}, 2'b10);
    tick();
    chk("t6_no_err", m0_err_out, 0);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
